ram: RTL and testbench
======================

RAM -- requirements
Module: ram

Interface
REQ-001 Parameter picture_size, default 28; image edge length; pixel and transposed-pixel depth = picture_size*picture_size (784).
REQ-002 Parameter SIZE_1, default 16; pixel data width.
REQ-003 Parameter SIZE_2, default 16; transposed-pixel data width.
REQ-004 Parameter SIZE_4, default 16; reserved, no function.
REQ-005 Parameter SIZE_9, default 16; weight data width.
REQ-006 Parameter SIZE_address_pix, default 16; pixel address width.
REQ-007 Parameter SIZE_address_pix_t, default 16; transposed-pixel address width.
REQ-008 Parameter SIZE_address_wei, default 16; weight address width.
REQ-009 Parameter DEPTH_W, default 1024; weight memory depth.
REQ-010 clk  input  1  sole clock; all state changes on the rising edge.
REQ-011 rst  input  1  reset, synchronous, active-high.
REQ-012 qp  output  SIZE_1 signed  registered pixel read data.
REQ-013 qtp  output  SIZE_2 signed  registered transposed-pixel read data.
REQ-014 qw  output  SIZE_9 signed  registered weight read data.
REQ-015 dp / dtp / dw  input  SIZE_1 / SIZE_2 / SIZE_9 signed  write data for the pixel / transposed / weight memory.
REQ-016 write_addressp, read_addressp  input  SIZE_address_pix  pixel write and read addresses.
REQ-017 write_addresstp, read_addresstp  input  SIZE_address_pix_t  transposed-pixel write and read addresses.
REQ-018 write_addressw, read_addressw  input  SIZE_address_wei  weight write and read addresses.
REQ-019 we_p, we_tp, we_w  input  1  write enables, active-high.
REQ-020 re_p, re_tp, re_w  input  1  read enables, active-high.
REQ-021 Positional port order: qp, qtp, qw, dp, dtp, dw, write_addressp, read_addressp, write_addresstp, read_addresstp, write_addressw, read_addressw, we_p, we_tp, we_w, re_p, re_tp, re_w, clk, rst.

Function
REQ-022 Three independent memories (pixel, transposed pixel, weight), each with one write port and one read port; no interaction between them.
REQ-023 Write: at a rising edge with we_x=1 and rst=0, mem_x[write_address_x] <= d_x; write latency 1 cycle.
REQ-024 Read: at a rising edge with re_x=1 and rst=0, q_x <= mem_x[read_address_x]; data valid on q_x after that edge (1-cycle latency).
REQ-025 With re_x=0, q_x holds its previous value.
REQ-026 Read and write to the same address in the same cycle: read returns the old contents (read-before-write); new data readable from the next cycle.
REQ-027 Write with address >= depth: ignored, memory unchanged.
REQ-028 Read with address >= depth: q_x <= 0.
REQ-029 Read and write enables of one memory may be asserted simultaneously at different addresses; both complete in the same cycle.
REQ-030 Data is stored and returned bit-exact; no sign extension, truncation or arithmetic.
REQ-031 Unwritten locations read as undefined; the bench must not rely on their value.

Reset
REQ-032 With rst=1 at a rising edge: qp, qtp, qw <= 0; writes and reads in that cycle are suppressed.
REQ-033 Reset does not clear memory contents; data written before reset remains readable after it.
REQ-034 Reset asserted mid-operation overrides the enables for that cycle only; normal operation resumes on the first edge with rst=0.

Verification
REQ-035 rst=1 for 2 cycles -> qp=qtp=qw=0.
REQ-036 dp=1, dtp=2, dw=3, addresses p=4, tp=5, w=6, all we=1 for one cycle; then all re=1 for one cycle -> qp=1, qtp=2, qw=3 one edge after re.
REQ-037 Read then re=0 for 3 cycles while the read addresses change -> qp/qtp/qw stay 1/2/3.
REQ-038 In one cycle write dp=-5 to pixel address 4 and read pixel address 4 -> qp=1 (old data); next read -> qp=-5 (0xFFFB).
REQ-039 Write dw=7 to weight address 1024 (>= DEPTH_W), read weight address 1024 -> qw=0, weight address 6 still reads 3.
REQ-040 Assert rst for one cycle with we_p=1, dp=9, write_addressp=4 -> qp=0, and a later read of pixel address 4 returns -5 (write suppressed, contents retained).

Source files
------------

// File: rtl/ram.sv
// ---------------------------------------------------------------------------
// ram : three independent simple-dual-port memories (pixel, transposed pixel,
// weight). Each memory has one write port and one registered read port.
//
// Ports
//   qp, qtp, qw                 registered read data (signed)
//   dp, dtp, dw                 write data (signed)
//   write_addressp / read_addressp     pixel write / read address
//   write_addresstp / read_addresstp   transposed-pixel write / read address
//   write_addressw / read_addressw     weight write / read address
//   we_p, we_tp, we_w           write enables, active-high
//   re_p, re_tp, re_w           read enables, active-high
//   clk                         sole clock, rising edge
//   rst                         synchronous active-high reset
//
// Behaviour
//   - Write and read complete on the same rising edge; a read of the address
//     being written returns the old word (read-before-write).
//   - Out-of-range writes are dropped; out-of-range reads return zero.
//   - With the read enable low the read register holds its value.
//   - rst clears the read registers and suppresses reads and writes for that
//     edge; memory contents are never cleared.
// ---------------------------------------------------------------------------
module ram #(
    parameter int picture_size        = 28,
    parameter int SIZE_1              = 16,
    parameter int SIZE_2              = 16,
    parameter int SIZE_4              = 16,
    parameter int SIZE_9              = 16,
    parameter int SIZE_address_pix    = 16,
    parameter int SIZE_address_pix_t  = 16,
    parameter int SIZE_address_wei    = 16,
    parameter int DEPTH_W             = 1024
) (
    output logic signed [SIZE_1-1:0]             qp,
    output logic signed [SIZE_2-1:0]             qtp,
    output logic signed [SIZE_9-1:0]             qw,
    input  logic signed [SIZE_1-1:0]             dp,
    input  logic signed [SIZE_2-1:0]             dtp,
    input  logic signed [SIZE_9-1:0]             dw,
    input  logic        [SIZE_address_pix-1:0]   write_addressp,
    input  logic        [SIZE_address_pix-1:0]   read_addressp,
    input  logic        [SIZE_address_pix_t-1:0] write_addresstp,
    input  logic        [SIZE_address_pix_t-1:0] read_addresstp,
    input  logic        [SIZE_address_wei-1:0]   write_addressw,
    input  logic        [SIZE_address_wei-1:0]   read_addressw,
    input  logic                                 we_p,
    input  logic                                 we_tp,
    input  logic                                 we_w,
    input  logic                                 re_p,
    input  logic                                 re_tp,
    input  logic                                 re_w,
    input  logic                                 clk,
    input  logic                                 rst
);

    localparam int DEPTH_P  = picture_size * picture_size;
    localparam int AW_P     = (DEPTH_P > 1) ? $clog2(DEPTH_P) : 1;
    localparam int AW_W     = (DEPTH_W > 1) ? $clog2(DEPTH_W) : 1;

    // SIZE_4 is a reserved width with no associated hardware.
    if (SIZE_4 > 0) begin : g_reserved
    end

    logic signed [SIZE_1-1:0] mem_p  [DEPTH_P];
    logic signed [SIZE_2-1:0] mem_tp [DEPTH_P];
    logic signed [SIZE_9-1:0] mem_w  [DEPTH_W];

    // Range checks are done on the full address; only then is the address
    // truncated to the array index width.
    logic wr_ok_p, rd_ok_p, wr_ok_tp, rd_ok_tp, wr_ok_w, rd_ok_w;

    always_comb begin
        wr_ok_p  = 32'(write_addressp)  < 32'(DEPTH_P);
        rd_ok_p  = 32'(read_addressp)   < 32'(DEPTH_P);
        wr_ok_tp = 32'(write_addresstp) < 32'(DEPTH_P);
        rd_ok_tp = 32'(read_addresstp)  < 32'(DEPTH_P);
        wr_ok_w  = 32'(write_addressw)  < 32'(DEPTH_W);
        rd_ok_w  = 32'(read_addressw)   < 32'(DEPTH_W);
    end

    // ---------------- pixel memory ----------------
    always_ff @(posedge clk) begin
        if (!rst && we_p && wr_ok_p)
            mem_p[write_addressp[AW_P-1:0]] <= dp;
    end

    always_ff @(posedge clk) begin
        if (rst)
            qp <= '0;
        else if (re_p)
            qp <= rd_ok_p ? mem_p[read_addressp[AW_P-1:0]] : '0;
    end

    // ---------------- transposed-pixel memory ----------------
    always_ff @(posedge clk) begin
        if (!rst && we_tp && wr_ok_tp)
            mem_tp[write_addresstp[AW_P-1:0]] <= dtp;
    end

    always_ff @(posedge clk) begin
        if (rst)
            qtp <= '0;
        else if (re_tp)
            qtp <= rd_ok_tp ? mem_tp[read_addresstp[AW_P-1:0]] : '0;
    end

    // ---------------- weight memory ----------------
    always_ff @(posedge clk) begin
        if (!rst && we_w && wr_ok_w)
            mem_w[write_addressw[AW_W-1:0]] <= dw;
    end

    always_ff @(posedge clk) begin
        if (rst)
            qw <= '0;
        else if (re_w)
            qw <= rd_ok_w ? mem_w[read_addressw[AW_W-1:0]] : '0;
    end

endmodule

// File: tb/tb_ram.sv
// ---------------------------------------------------------------------------
// tb_ram : directed steps followed by a randomized phase checked against a
// per-memory associative-array model. Index 0 = pixel, 1 = transposed pixel,
// 2 = weight.
// ---------------------------------------------------------------------------
module tb_ram;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] d  [3];
  logic [15:0] wa [3];
  logic [15:0] ra [3];
  logic        we [3];
  logic        re [3];
  logic [15:0] q  [3];

  int tests = 0;
  int fails = 0;

  int          dep [3];
  logic [15:0] mdl [3][int];
  logic [15:0] exp_q [3];
  logic        known [3];

  always #5 clk = ~clk;

  ram dut (
    .qp(q[0]), .qtp(q[1]), .qw(q[2]),
    .dp(d[0]), .dtp(d[1]), .dw(d[2]),
    .write_addressp(wa[0]), .read_addressp(ra[0]),
    .write_addresstp(wa[1]), .read_addresstp(ra[1]),
    .write_addressw(wa[2]), .read_addressw(ra[2]),
    .we_p(we[0]), .we_tp(we[1]), .we_w(we[2]),
    .re_p(re[0]), .re_tp(re[1]), .re_w(re[2]),
    .clk(clk), .rst(rst)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    for (int m = 0; m < 3; m++) begin
      d[m] = '0; wa[m] = '0; ra[m] = '0; we[m] = 1'b0; re[m] = 1'b0;
    end
  endtask

  initial begin
    dep[0] = 784; dep[1] = 784; dep[2] = 1024;
    rst = 1'b1;
    idle();

    // Reset for two cycles.
    step(); step();
    check("rst_qp", q[0], 16'h0);
    check("rst_qtp", q[1], 16'h0);
    check("rst_qw", q[2], 16'h0);
    rst = 1'b0;

    // Write 1/2/3 to addresses 4/5/6, then read them back.
    d[0] = 16'd1; d[1] = 16'd2; d[2] = 16'd3;
    wa[0] = 16'd4; wa[1] = 16'd5; wa[2] = 16'd6;
    we[0] = 1'b1; we[1] = 1'b1; we[2] = 1'b1;
    step();
    idle();
    ra[0] = 16'd4; ra[1] = 16'd5; ra[2] = 16'd6;
    re[0] = 1'b1; re[1] = 1'b1; re[2] = 1'b1;
    step();
    check("rd_qp", q[0], 16'd1);
    check("rd_qtp", q[1], 16'd2);
    check("rd_qw", q[2], 16'd3);

    // Hold with re low while read addresses move.
    idle();
    for (int i = 0; i < 3; i++) begin
      ra[0] = 16'(10 + i); ra[1] = 16'(20 + i); ra[2] = 16'(30 + i);
      step();
      check("hold_qp", q[0], 16'd1);
      check("hold_qtp", q[1], 16'd2);
      check("hold_qw", q[2], 16'd3);
    end

    // Read-before-write at the same pixel address.
    idle();
    d[0] = 16'hFFFB; wa[0] = 16'd4; we[0] = 1'b1;
    ra[0] = 16'd4; re[0] = 1'b1;
    step();
    check("rbw_old", q[0], 16'd1);
    we[0] = 1'b0;
    step();
    check("rbw_new", q[0], 16'hFFFB);

    // Out-of-range weight write and read.
    idle();
    d[2] = 16'd7; wa[2] = 16'd1024; we[2] = 1'b1;
    ra[2] = 16'd1024; re[2] = 1'b1;
    step();
    check("oor_rd", q[2], 16'h0);
    we[2] = 1'b0; ra[2] = 16'd6;
    step();
    check("oor_keep", q[2], 16'd3);

    // Mid-operation reset suppresses write and read.
    idle();
    rst = 1'b1;
    d[0] = 16'd9; wa[0] = 16'd4; we[0] = 1'b1;
    ra[0] = 16'd4; re[0] = 1'b1;
    re[2] = 1'b1; ra[2] = 16'd6;
    step();
    check("mrst_qp", q[0], 16'h0);
    check("mrst_qw", q[2], 16'h0);
    rst = 1'b0;
    we[0] = 1'b0;
    step();
    check("mrst_keep", q[0], 16'hFFFB);
    check("mrst_qw_back", q[2], 16'd3);

    // Randomized phase against the model.
    mdl[0][4] = 16'hFFFB;
    mdl[1][5] = 16'd2;
    mdl[2][6] = 16'd3;
    for (int m = 0; m < 3; m++) begin
      exp_q[m] = q[m];
      known[m] = 1'b0;
    end
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 39) == 0);
      for (int m = 0; m < 3; m++) begin
        d[m]  = 16'($urandom);
        we[m] = 1'($urandom);
        re[m] = 1'($urandom);
        wa[m] = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(dep[m], 65535))
                                            : 16'($urandom_range(0, 15));
        ra[m] = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(dep[m], 65535))
                                            : 16'($urandom_range(0, 15));
        // Read result uses contents before this cycle's write.
        if (rst) begin
          exp_q[m] = '0; known[m] = 1'b1;
        end else if (re[m]) begin
          if (int'(ra[m]) >= dep[m]) begin
            exp_q[m] = '0; known[m] = 1'b1;
          end else if (mdl[m].exists(int'(ra[m]))) begin
            exp_q[m] = mdl[m][int'(ra[m])]; known[m] = 1'b1;
          end else begin
            known[m] = 1'b0;
          end
        end
        if (!rst && we[m] && int'(wa[m]) < dep[m])
          mdl[m][int'(wa[m])] = d[m];
      end
      step();
      for (int m = 0; m < 3; m++)
        if (known[m]) check($sformatf("rand_q%0d", m), q[m], exp_q[m]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
